// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter sharing a single-ported synchronous-read word memory
module mem_arbiter #(
    parameter int AWIDTH    = 30,
    parameter int DWIDTH    = 32,
    parameter int RD_LAT    = 1,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [AWIDTH-1:0] m0_addr,
    input  logic [DWIDTH-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DWIDTH-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [AWIDTH-1:0] m1_addr,
    input  logic [DWIDTH-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DWIDTH-1:0] m1_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    logic              last_gnt;
    logic              lock_vld;
    logic              lock_id;
    logic              mem_owner;
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_id;

    logic              allow0, allow1, r0, r1, pick1, xfer;
    logic              win_we, win_lock, owner_lock;
    logic [AWIDTH-1:0] win_addr;
    logic [DWIDTH-1:0] win_wdata;

    // A lock owner shuts out the other master regardless of priority mode.
    assign allow0 = !lock_vld || !lock_id;
    assign allow1 = !lock_vld ||  lock_id;
    assign r0     = m0_req && allow0;
    assign r1     = m1_req && allow1;

    always_comb begin
        pick1 = r1;
        if (r0 && r1) begin
            pick1 = (PRIO_MODE == 0) && !last_gnt;
        end
    end

    assign m0_gnt     = r0 && !pick1;
    assign m1_gnt     = r1 &&  pick1;
    assign xfer       = m0_gnt || m1_gnt;
    assign win_we     = pick1 ? m1_we    : m0_we;
    assign win_lock   = pick1 ? m1_lock  : m0_lock;
    assign win_addr   = pick1 ? m1_addr  : m0_addr;
    assign win_wdata  = pick1 ? m1_wdata : m0_wdata;
    assign owner_lock = lock_id ? m1_lock : m0_lock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_owner <= 1'b0;
            last_gnt  <= 1'b1;
            lock_vld  <= 1'b0;
            lock_id   <= 1'b0;
            tag_vld   <= '0;
            tag_id    <= '0;
        end else begin
            mem_re <= xfer && !win_we;
            mem_we <= xfer &&  win_we;
            if (xfer) begin
                mem_addr  <= win_addr;
                mem_wdata <= win_wdata;
                mem_owner <= pick1;
                last_gnt  <= pick1;
            end
            if (xfer && win_lock) begin
                lock_vld <= 1'b1;
                lock_id  <= pick1;
            end else if (lock_vld && !owner_lock) begin
                lock_vld <= 1'b0;
            end
            // Tag shifts in step with the memory's read pipeline.
            tag_vld[0] <= mem_re;
            tag_id[0]  <= mem_owner;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    assign m0_rvalid = tag_vld[RD_LAT-1] && !tag_id[RD_LAT-1];
    assign m1_rvalid = tag_vld[RD_LAT-1] &&  tag_id[RD_LAT-1];
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed checks of mem_arbiter: u0 round-robin RD_LAT=1, u1 fixed-priority RD_LAT=3
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [29:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;

    logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_mem_re, a_mem_we;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_wdata, a_mem_rdata;
    logic [29:0] a_mem_addr;
    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_re, b_mem_we;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_wdata, b_mem_rdata;
    logic [29:0] b_mem_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AWIDTH(30), .DWIDTH(32), .RD_LAT(1), .PRIO_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
        .mem_re(a_mem_re), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata)
    );

    mem_arbiter #(.AWIDTH(30), .DWIDTH(32), .RD_LAT(3), .PRIO_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [3];

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 32'h1000_0000 + i;
            mem_b[i] = 32'h1000_0000 + i;
        end
        mem_a[5] = 32'hDEAD_BEEF;
        mem_b[5] = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        if (a_mem_we) mem_a[a_mem_addr[3:0]] <= a_mem_wdata;
        if (a_mem_re) pipe_a <= mem_a[a_mem_addr[3:0]];
        if (b_mem_we) mem_b[b_mem_addr[3:0]] <= b_mem_wdata;
        if (b_mem_re) pipe_b[0] <= mem_b[b_mem_addr[3:0]];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign a_mem_rdata = pipe_a;
    assign b_mem_rdata = pipe_b[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_req();
        m0_req = 0; m0_we = 0; m0_lock = 0;
        m1_req = 0; m1_we = 0; m1_lock = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            clear_req();
        end
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic        exp_m1;
        rst_n = 0;
        clear_req();
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        repeat (2) @(posedge clk);
        sample();
        check("rst_mem_re", a_mem_re, 0);
        check("rst_mem_we", a_mem_we, 0);
        check("rst_mem_addr", a_mem_addr, 0);
        check("rst_mem_wdata", a_mem_wdata, 0);
        check("rst_rvalid", {b_m0_rvalid, b_m1_rvalid, a_m0_rvalid, a_m1_rvalid}, 0);
        check("rst_gnt_idle", {a_m0_gnt, a_m1_gnt}, 0);
        tick();
        rst_n = 1;

        // Both masters read every cycle: u0 alternates, u1 always picks m0.
        for (int c = 0; c < 9; c++) begin
            tick();
            clear_req();
            if (c < 6) begin
                m0_req = 1; m1_req = 1; m0_addr = c; m1_addr = 8 + c;
            end else if (c == 6) begin
                m1_req = 1; m1_addr = 15;
            end
            sample();
            if (c < 6) begin
                check("rr_g0", a_m0_gnt, (c % 2) == 0);
                check("rr_g1", a_m1_gnt, (c % 2) == 1);
                check("fp_g0", b_m0_gnt, 1);
                check("fp_g1", b_m1_gnt, 0);
            end
            if (c == 6) begin
                check("rr_m1_alone", a_m1_gnt, 1);
                check("fp_m1_drop", b_m1_gnt, 1);
            end
            if (c >= 2) begin
                exp_m1   = (c == 8) || ((c - 2) % 2 == 1);
                exp_addr = (c == 8) ? 15 : (exp_m1 ? 8 + c - 2 : c - 2);
                check("rr_rv0", a_m0_rvalid, !exp_m1);
                check("rr_rv1", a_m1_rvalid, exp_m1);
                check("rr_data", exp_m1 ? a_m1_rdata : a_m0_rdata, 32'h1000_0000 + exp_addr);
            end
        end
        idle(4);

        // Single read of word 5.
        tick();
        clear_req();
        m0_req = 1; m0_addr = 5;
        sample();
        check("sr_g0", a_m0_gnt, 1);
        check("sr_g1", a_m1_gnt, 0);
        tick();
        clear_req();
        sample();
        check("sr_mem_re", a_mem_re, 1);
        check("sr_mem_addr", a_mem_addr, 5);
        tick();
        sample();
        check("sr_rv0", a_m0_rvalid, 1);
        check("sr_data", a_m0_rdata, 32'hDEAD_BEEF);
        check("sr_rv1", a_m1_rvalid, 0);
        tick();
        sample();
        check("sr_rv0_once", a_m0_rvalid, 0);
        idle(4);

        // Lock: m1 locked write then locked read while m0 keeps requesting.
        tick();
        clear_req();
        m0_req = 1; m0_addr = 0;
        m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 8; m1_wdata = 32'h1;
        sample();
        check("lk_g1_wr", a_m1_gnt, 1);
        check("lk_g0_c0", a_m0_gnt, 0);
        tick();
        m1_we = 0;
        sample();
        check("lk_g1_rd", a_m1_gnt, 1);
        check("lk_g0_c1", a_m0_gnt, 0);
        check("lk_mem_we", a_mem_we, 1);
        check("lk_mem_addr", a_mem_addr, 8);
        tick();
        m1_req = 0;
        sample();
        check("lk_g0_c2", a_m0_gnt, 0);
        check("lk_mem_re", a_mem_re, 1);
        tick();
        m1_lock = 0;
        sample();
        check("lk_g0_c3", a_m0_gnt, 0);
        check("lk_rv1", a_m1_rvalid, 1);
        check("lk_data", a_m1_rdata, 32'h1);
        tick();
        sample();
        check("lk_g0_free", a_m0_gnt, 1);
        tick();
        clear_req();
        tick();
        sample();
        check("lk_m0_rv", a_m0_rvalid, 1);
        check("lk_m0_data", a_m0_rdata, 32'h1000_0000);
        idle(5);

        // Write then read of the same word; u1 shows RD_LAT=3.
        tick();
        clear_req();
        m1_req = 1; m1_we = 1; m1_addr = 3; m1_wdata = 32'hCAFE_0001;
        sample();
        check("wr_g1", a_m1_gnt, 1);
        tick();
        clear_req();
        m0_req = 1; m0_addr = 3;
        sample();
        check("wr_rd_g0", a_m0_gnt, 1);
        tick();
        clear_req();
        tick();
        sample();
        check("wr_rv_l1", a_m0_rvalid, 1);
        check("wr_data_l1", a_m0_rdata, 32'hCAFE_0001);
        check("wr_rv_l3_early", b_m0_rvalid, 0);
        tick();
        sample();
        check("wr_rv_l1_once", a_m0_rvalid, 0);
        check("wr_rv_l3_c4", b_m0_rvalid, 0);
        tick();
        sample();
        check("wr_rv_l3", b_m0_rvalid, 1);
        check("wr_data_l3", b_m0_rdata, 32'hCAFE_0001);
        idle(6);

        // Reset lands on an in-flight read.
        tick();
        clear_req();
        m0_req = 1; m0_addr = 5;
        sample();
        check("rs_g0", a_m0_gnt, 1);
        tick();
        clear_req();
        rst_n = 0;
        sample();
        check("rs_mem_re_a", a_mem_re, 0);
        check("rs_mem_re_b", b_mem_re, 0);
        for (int c = 2; c < 7; c++) begin
            tick();
            if (c == 3) rst_n = 1;
            sample();
            check("rs_no_rvalid", {a_m0_rvalid, a_m1_rvalid, b_m0_rvalid, b_m1_rvalid}, 0);
        end
        tick();
        m0_req = 1; m1_req = 1; m0_addr = 1; m1_addr = 2;
        sample();
        check("rs_conf_g0", a_m0_gnt, 1);
        check("rs_conf_g1", a_m1_gnt, 0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
